// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: register map, status/control bit
// positions and the transfer FSM state type.
package spi_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOP     = 3'd6;

    localparam int BIT_ROE  = 3;
    localparam int BIT_TOE  = 4;
    localparam int BIT_TRDY = 6;
    localparam int BIT_RRDY = 7;
    localparam int BIT_E    = 8;
    localparam int BIT_EOP  = 9;

    // Interrupt enables that exist in every build; EOP is added by the top.
    localparam logic [15:0] CTRL_MASK_BASE = (16'h1 << BIT_ROE)  | (16'h1 << BIT_TOE)  |
                                             (16'h1 << BIT_TRDY) | (16'h1 << BIT_RRDY) |
                                             (16'h1 << BIT_E);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall
// pulses derived from one extra delayed copy of the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_d <= RESET_VAL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/project_soc_spi_slave.sv
// SPI mode-0 slave (MSB first) with an Avalon-MM register interface.
// Optional end-of-packet detection is enabled by defining SPI_SLAVE_EOP_EN.
module project_soc_spi_slave
    import spi_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int CNT_W = $clog2(DATABITS + 1);
`ifdef SPI_SLAVE_EOP_EN
    localparam logic [15:0] CTRL_MASK = CTRL_MASK_BASE | (16'h1 << BIT_EOP);
`else
    localparam logic [15:0] CTRL_MASK = CTRL_MASK_BASE;
`endif

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync_outputs;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(SCLK), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(SS_n), .level(ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(MOSI), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync_outputs = sclk_s ^ mosi_rise ^ mosi_fall;

    spi_state_e          state;
    logic [CNT_W-1:0]    bitcnt;
    logic [DATABITS-1:0] shift_reg, rx_shift, rx_holding, tx_holding, rx_next;
    logic                roe, toe, trdy, rrdy;
    logic [15:0]         control, status, rd_mux;
    logic                rd_req, wr_req, rd_req_d, wr_req_d, rd_stb, wr_stb;
    logic                rx_read, tx_write, status_write, ctrl_write;
    logic                byte_done, load_shift, tx_accept;
`ifdef SPI_SLAVE_EOP_EN
    logic                eop, got_byte, eop_write;
    logic [DATABITS-1:0] eop_value;
`endif

    assign rd_req = spi_select & ~read_n;
    assign wr_req = spi_select & ~write_n;
    assign rd_stb = rd_req & ~rd_req_d;
    assign wr_stb = wr_req & ~wr_req_d;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        rx_next      = DATABITS'({rx_shift, mosi_s});
        rx_read      = rd_stb && (mem_addr == ADDR_RXDATA);
        tx_write     = wr_stb && (mem_addr == ADDR_TXDATA);
        status_write = wr_stb && (mem_addr == ADDR_STATUS);
        ctrl_write   = wr_stb && (mem_addr == ADDR_CONTROL);
        byte_done    = (state == ACTIVE) && !ss_rise && sclk_rise &&
                       (bitcnt == CNT_W'(DATABITS - 1));
        load_shift   = ((state == IDLE) && ss_fall) ||
                       ((state == ACTIVE) && !ss_rise && sclk_fall && (bitcnt == '0));
        // A shift load that consumes the primed byte frees the holding
        // register for a CPU write landing in the same cycle.
        tx_accept    = trdy || load_shift;
`ifdef SPI_SLAVE_EOP_EN
        eop_write    = wr_stb && (mem_addr == ADDR_EOP);
`endif
    end

    always_comb begin
        status           = '0;
        status[BIT_ROE]  = roe;
        status[BIT_TOE]  = toe;
        status[BIT_TRDY] = trdy;
        status[BIT_RRDY] = rrdy;
        status[BIT_E]    = roe | toe;
`ifdef SPI_SLAVE_EOP_EN
        status[BIT_EOP]  = eop;
`endif
        rd_mux = '0;
        case (mem_addr)
            ADDR_RXDATA:  rd_mux = 16'(rx_holding);
            ADDR_STATUS:  rd_mux = status;
            ADDR_CONTROL: rd_mux = control;
`ifdef SPI_SLAVE_EOP_EN
            ADDR_EOP:     rd_mux = 16'(eop_value);
`endif
            default:      rd_mux = '0;
        endcase
    end

    // NOTE: later non-blocking assignments in this block override earlier
    // ones, which encodes the priority between SPI events and CPU accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bitcnt      <= '0;
            shift_reg   <= '0;
            rx_shift    <= '0;
            rx_holding  <= '0;
            tx_holding  <= '0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            trdy        <= 1'b1;
            rrdy        <= 1'b0;
            control     <= '0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
            rd_req_d    <= 1'b0;
            wr_req_d    <= 1'b0;
`ifdef SPI_SLAVE_EOP_EN
            eop         <= 1'b0;
            got_byte    <= 1'b0;
            eop_value   <= '0;
`endif
        end else begin
            rd_req_d <= rd_req;
            wr_req_d <= wr_req;
            irq      <= |(status & control);
            if (rd_stb) data_to_cpu <= rd_mux;

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state  <= ACTIVE;
                        bitcnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state  <= IDLE;
                        bitcnt <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bitcnt   <= byte_done ? '0 : bitcnt + CNT_W'(1);
                    end else if (sclk_fall && (bitcnt != '0)) begin
                        shift_reg <= shift_reg << 1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_shift) begin
                shift_reg <= trdy ? '0 : tx_holding;
                if (trdy) toe  <= 1'b1;
                else      trdy <= 1'b1;
            end
            if (byte_done) rx_holding <= rx_next;

            if (status_write) begin
                roe <= 1'b0;
                toe <= 1'b0;
            end
            if (tx_write) begin
                if (tx_accept) begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    trdy       <= 1'b0;
                end else begin
                    toe <= 1'b1;
                end
            end
            if (rx_read) rrdy <= 1'b0;
            if (byte_done) begin
                rrdy <= 1'b1;
                if (rrdy && !rx_read) roe <= 1'b1;
            end
            if (ctrl_write) control <= data_from_cpu & CTRL_MASK;

`ifdef SPI_SLAVE_EOP_EN
            if ((state == IDLE) && ss_fall) got_byte <= 1'b0;
            if (byte_done) got_byte <= 1'b1;
            if (status_write) eop <= 1'b0;
            if ((byte_done && (rx_next == eop_value)) ||
                ((state == ACTIVE) && ss_rise && got_byte)) eop <= 1'b1;
            if (eop_write) eop_value <= data_from_cpu[DATABITS-1:0];
`endif
        end
    end

    assign MISO_oe       = (state == ACTIVE) && !ss_s;
    assign MISO          = MISO_oe & shift_reg[DATABITS-1];
    assign dataavailable = rrdy;
    assign readyfordata  = trdy;

endmodule

// File: tb/tb_project_soc_spi_slave.sv
// Directed bench for project_soc_spi_slave: a transaction-level model of the
// register file and byte stream, checked every settled cycle and at each SCLK rise.
module tb_project_soc_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        irq, dataavailable, readyfordata;

    project_soc_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata));

    always #5 clk = ~clk;

`ifdef SPI_SLAVE_EOP_EN
    localparam logic [15:0] TB_CTRL_MASK = 16'h03D8;
`else
    localparam logic [15:0] TB_CTRL_MASK = 16'h01D8;
`endif

    int checks = 0;
    int failures = 0;
    bit settled = 1'b0;

    // Model state: what the CPU and the master must observe.
    logic        m_sel, m_trdy, m_rrdy, m_roe, m_toe, m_eop;
    logic [7:0]  m_tx, m_rx, m_cur, m_rx_shift, m_eop_val, miso_cap;
    logic [15:0] m_ctrl, rd;
    int          m_pos, m_bytes;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s    = '0;
        s[3] = m_roe;
        s[4] = m_toe;
        s[6] = m_trdy;
        s[7] = m_rrdy;
        s[8] = m_roe | m_toe;
`ifdef SPI_SLAVE_EOP_EN
        s[9] = m_eop;
`endif
        return s;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {8'h00, m_rx};
            3'd2: return model_status();
            3'd3: return m_ctrl;
`ifdef SPI_SLAVE_EOP_EN
            3'd6: return {8'h00, m_eop_val};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_sel = 0; m_trdy = 1; m_rrdy = 0; m_roe = 0; m_toe = 0; m_eop = 0;
        m_tx = 0; m_rx = 0; m_cur = 0; m_rx_shift = 0; m_eop_val = 0;
        m_ctrl = 0; m_pos = 0; m_bytes = 0;
    endtask

    task automatic model_load();
        if (!m_trdy) begin
            m_cur  = m_tx;
            m_trdy = 1;
        end else begin
            m_cur = 8'h00;
            m_toe = 1;
        end
        m_pos = 0;
    endtask

    task automatic model_byte_done();
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1;
        m_rx   = m_rx_shift;
        m_bytes++;
`ifdef SPI_SLAVE_EOP_EN
        if (m_rx_shift == m_eop_val) m_eop = 1;
`endif
    endtask

    // Per-cycle comparison against the model whenever the DUT has settled.
    always @(negedge clk) begin
        if (settled && reset_n) begin
            check("cyc_miso_oe", {15'd0, MISO_oe}, {15'd0, m_sel});
            check("cyc_miso", {15'd0, MISO}, {15'd0, m_sel ? m_cur[7-m_pos] : 1'b0});
            check("cyc_trdy", {15'd0, readyfordata}, {15'd0, m_trdy});
            check("cyc_rrdy", {15'd0, dataavailable}, {15'd0, m_rrdy});
            check("cyc_irq", {15'd0, irq}, {15'd0, |(model_status() & m_ctrl)});
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        settled = 0;
        @(posedge clk); #1;
        spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
        repeat (2) @(posedge clk);
        #1 spi_select = 0; write_n = 1;
        case (a)
            3'd1: if (m_trdy) begin m_tx = d[7:0]; m_trdy = 0; end else m_toe = 1;
            3'd2: begin m_roe = 0; m_toe = 0; m_eop = 0; end
            3'd3: m_ctrl = d & TB_CTRL_MASK;
`ifdef SPI_SLAVE_EOP_EN
            3'd6: m_eop_val = d[7:0];
`endif
            default: ;
        endcase
        repeat (2) @(posedge clk);
        settled = 1;
    endtask

    task automatic cpu_read(input logic [2:0] a, input string name, output logic [15:0] d);
        logic [15:0] exp;
        settled = 0;
        exp = model_read(a);
        @(posedge clk); #1;
        spi_select = 1; read_n = 0; mem_addr = a;
        @(posedge clk); #1;
        d = data_to_cpu;
        check(name, d, exp);
        @(posedge clk); #1;
        spi_select = 0; read_n = 1;
        if (a == 3'd0) m_rrdy = 0;
        repeat (2) @(posedge clk);
        settled = 1;
    endtask

    task automatic ss_low();
        settled = 0;
        @(posedge clk); #1 SS_n = 0;
        m_sel = 1; m_bytes = 0; m_rx_shift = 0; miso_cap = 0;
        model_load();
        repeat (6) @(posedge clk);
        settled = 1;
    endtask

    task automatic ss_high();
        settled = 0;
        repeat (3) @(posedge clk);
        #1 SS_n = 1;
`ifdef SPI_SLAVE_EOP_EN
        if (m_bytes > 0) m_eop = 1;
`endif
        m_sel = 0;
        repeat (8) @(posedge clk);
        settled = 1;
    endtask

    // SCLK = clk/10; the master samples MISO on each SCLK rise.
    task automatic send_bits(input logic [15:0] v, input int n);
        settled = 0;
        for (int i = 0; i < n; i++) begin
            MOSI = v[n-1-i];
            repeat (5) @(posedge clk);
            #1;
            check("miso_at_rise", {15'd0, MISO}, {15'd0, m_cur[7-m_pos]});
            miso_cap = {miso_cap[6:0], MISO};
            SCLK = 1;
            m_rx_shift = {m_rx_shift[6:0], v[n-1-i]};
            m_pos++;
            if (m_pos == 8) model_byte_done();
            repeat (5) @(posedge clk);
            #1 SCLK = 0;
            if (m_pos == 8) model_load();
        end
        repeat (8) @(posedge clk);
        settled = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; SCLK = 0; SS_n = 1; MOSI = 0;
        spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check("rst_miso", {15'd0, MISO}, 16'd0);
        check("rst_miso_oe", {15'd0, MISO_oe}, 16'd0);
        check("rst_data", data_to_cpu, 16'd0);
        check("rst_irq", {15'd0, irq}, 16'd0);
        check("rst_trdy", {15'd0, readyfordata}, 16'd1);
        check("rst_rrdy", {15'd0, dataavailable}, 16'd0);
        reset_n = 1;
        repeat (3) @(posedge clk);
        settled = 1;
        cpu_read(3'd2, "rst_status", rd);
        check("rst_status_lit", rd, 16'h0040);
        cpu_read(3'd3, "rst_control", rd);

        // Primed 0xA5 out, 0x3C in.
        cpu_write(3'd1, 16'h00A5);
        ss_low();
        send_bits(16'h003C, 8);
        ss_high();
        check("t1_miso_byte", {8'h00, miso_cap}, 16'h00A5);
        check("t1_trdy", {15'd0, readyfordata}, 16'd1);
        check("t1_rrdy_before", {15'd0, dataavailable}, 16'd1);
        cpu_read(3'd0, "t1_rxdata", rd);
        check("t1_rxdata_lit", rd, 16'h003C);
        check("t1_rrdy_after", {15'd0, dataavailable}, 16'd0);

        // Two bytes without reading: overrun and ROE interrupt.
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0008);
        ss_low();
        send_bits(16'h1122, 16);
        ss_high();
        cpu_read(3'd2, "t2_status", rd);
        check("t2_roe_lit", {15'd0, rd[3]}, 16'd1);
        check("t2_e_lit", {15'd0, rd[8]}, 16'd1);
        check("t2_irq_lit", {15'd0, irq}, 16'd1);
        cpu_read(3'd0, "t2_rxdata", rd);
        check("t2_rxdata_lit", rd, 16'h0022);
        settled = 0;
        @(posedge clk); #1;
        spi_select = 1; write_n = 0; mem_addr = 3'd2; data_from_cpu = 16'h0000;
        @(posedge clk); #1;
        check("t2_irq_latency_hold", {15'd0, irq}, 16'd1);
        @(posedge clk); #1;
        check("t2_irq_cleared", {15'd0, irq}, 16'd0);
        spi_select = 0; write_n = 1;
        m_roe = 0; m_toe = 0; m_eop = 0;
        repeat (2) @(posedge clk);
        settled = 1;

        // Underrun: nothing primed, MISO stays low.
        ss_low();
        send_bits(16'h005A, 8);
        ss_high();
        check("t3_miso_zero", {8'h00, miso_cap}, 16'h0000);
        cpu_read(3'd2, "t3_status", rd);
        check("t3_toe_lit", {15'd0, rd[4]}, 16'd1);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, "t3_status_clr", rd);
        check("t3_toe_clr_lit", {15'd0, rd[4]}, 16'd0);
        cpu_read(3'd0, "t3_rxdata", rd);

        // Partial frame discarded, next full frame intact.
        cpu_write(3'd1, 16'h0096);
        ss_low();
        send_bits(16'h001F, 5);
        ss_high();
        check("t4_partial_rrdy", {15'd0, dataavailable}, 16'd0);
        ss_low();
        send_bits(16'h0081, 8);
        ss_high();
        cpu_read(3'd0, "t4_rxdata", rd);
        check("t4_rxdata_lit", rd, 16'h0081);

        // Reset in the middle of a frame.
        cpu_write(3'd3, 16'h0040);
        cpu_read(3'd2, "t5_status", rd);
        check("t5_irq_before", {15'd0, irq}, 16'd1);
        ss_low();
        send_bits(16'h000A, 4);
        settled = 0;
        @(posedge clk); #1 reset_n = 0;
        #1;
        check("t5_rst_miso", {15'd0, MISO}, 16'd0);
        check("t5_rst_miso_oe", {15'd0, MISO_oe}, 16'd0);
        check("t5_rst_data", data_to_cpu, 16'd0);
        check("t5_rst_irq", {15'd0, irq}, 16'd0);
        check("t5_rst_trdy", {15'd0, readyfordata}, 16'd1);
        check("t5_rst_rrdy", {15'd0, dataavailable}, 16'd0);
        model_reset();
        SS_n = 1; SCLK = 0; MOSI = 0;
        repeat (4) @(posedge clk); #1 reset_n = 1;
        repeat (4) @(posedge clk);
        settled = 1;
        ss_low();
        send_bits(16'h00F0, 8);
        ss_high();
        cpu_read(3'd0, "t5_rxdata", rd);
        check("t5_rxdata_lit", rd, 16'h00F0);
        cpu_read(3'd1, "txdata_reads_zero", rd);
        cpu_read(3'd5, "unmapped_reads_zero", rd);

`ifdef SPI_SLAVE_EOP_EN
        cpu_write(3'd6, 16'h000D);
        cpu_read(3'd6, "t6_eop_reg", rd);
        check("t6_eop_reg_lit", rd, 16'h000D);
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0200);
        ss_low();
        send_bits(16'h0041, 8);
        cpu_read(3'd2, "t6_status_b1", rd);
        check("t6_eop_b1_lit", {15'd0, rd[9]}, 16'd0);
        send_bits(16'h000D, 8);
        cpu_read(3'd2, "t6_status_b2", rd);
        check("t6_eop_b2_lit", {15'd0, rd[9]}, 16'd1);
        check("t6_irq_lit", {15'd0, irq}, 16'd1);
        ss_high();
`else
        cpu_write(3'd6, 16'h000D);
        cpu_read(3'd6, "eop_reg_absent", rd);
        check("eop_reg_absent_lit", rd, 16'h0000);
`endif

        settled = 0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
